// File: rtl/gpu_stencil_pkg.sv
// gpu_stencil_pkg
// Shared definitions for the stencil store:
//   - clr_state_e   : clear FSM state encoding (IDLE / CLEAR)
//   - calc_bb       : bank-select bit count from the bank count
//   - calc_depth    : words per bank from address width and bank bits
//   - addr_bank     : bank index field of a word address (low bits)
//   - addr_word     : word index field of a word address (high bits)
package gpu_stencil_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int calc_bb(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int calc_depth(input int addr_w, input int bb);
    return 1 << (addr_w - bb);
  endfunction

  // Banks interleave on the low address bits so consecutive addresses
  // land in different banks.
  function automatic int unsigned addr_bank(input logic [31:0] addr, input int bb);
    return int'(addr & ((32'd1 << bb) - 32'd1));
  endfunction

  function automatic int unsigned addr_word(input logic [31:0] addr, input int bb);
    return int'(addr >> bb);
  endfunction

endpackage

// File: rtl/gpu_stencil_bank.sv
// gpu_stencil_bank
// One bank of the stencil store: a word RAM with one combinational read
// port, one read port for the read-modify-write fetch and one write port,
// plus the one-entry merge stage for partial-mask writes.
//
// Optional feature: define STENCIL_WR_FWD_EN to forward the word being
// committed this cycle onto rd_data_o when the read targets the same word.
//
// Ports:
//   clk_i, rst_ni    clock, async active-low reset (merge stage only)
//   rd_word_i        word index of the external read
//   rd_data_o        word read (combinational)
//   wr_en_i          accepted write with non-zero mask targets this bank
//   wr_word_i        write word index
//   wr_mask_i        per-bit write enable
//   wr_value_i       write data
//   clr_en_i         clear sweep active: write clr_value_i at clr_word_i
//   clr_word_i       clear sweep word index
//   clr_value_i      fill value
//   rmw_pending_o    merge stage holds a partial write to commit this cycle
module gpu_stencil_bank #(
  parameter int DATA_W = 16,
  parameter int WORD_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [DATA_W-1:0] wr_mask_i,
  input  logic [DATA_W-1:0] wr_value_i,
  input  logic              clr_en_i,
  input  logic [WORD_W-1:0] clr_word_i,
  input  logic [DATA_W-1:0] clr_value_i,
  output logic              rmw_pending_o
);

  localparam int DEPTH = 1 << WORD_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rmw_pend_q;
  logic [WORD_W-1:0] rmw_word_q;
  logic [DATA_W-1:0] rmw_mask_q;
  logic [DATA_W-1:0] rmw_value_q;
  logic [DATA_W-1:0] rmw_old_q;

  logic              wr_full;
  logic              rmw_start;
  logic [DATA_W-1:0] merged;
  logic              commit_en;
  logic [WORD_W-1:0] commit_word;
  logic [DATA_W-1:0] commit_data;

  assign wr_full   = &wr_mask_i;
  assign rmw_start = wr_en_i & ~wr_full;
  assign merged    = (rmw_value_q & rmw_mask_q) | (rmw_old_q & ~rmw_mask_q);

  // The three write sources never overlap: a clear cannot start while a
  // merge is pending, and no write is accepted while one is pending or
  // while clearing. The priority order is only a tie-break for safety.
  always_comb begin
    commit_en   = 1'b0;
    commit_word = wr_word_i;
    commit_data = wr_value_i;
    if (clr_en_i) begin
      commit_en   = 1'b1;
      commit_word = clr_word_i;
      commit_data = clr_value_i;
    end else if (rmw_pend_q) begin
      commit_en   = 1'b1;
      commit_word = rmw_word_q;
      commit_data = merged;
    end else if (wr_en_i && wr_full) begin
      commit_en   = 1'b1;
      commit_word = wr_word_i;
      commit_data = wr_value_i;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (commit_en) begin
      mem[commit_word] <= commit_data;
    end
  end

  // Merge stage: capture the old word in the accept cycle, commit next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rmw_pend_q  <= 1'b0;
      rmw_word_q  <= '0;
      rmw_mask_q  <= '0;
      rmw_value_q <= '0;
      rmw_old_q   <= '0;
    end else begin
      rmw_pend_q <= rmw_start;
      if (rmw_start) begin
        rmw_word_q  <= wr_word_i;
        rmw_mask_q  <= wr_mask_i;
        rmw_value_q <= wr_value_i;
        rmw_old_q   <= mem[wr_word_i];
      end
    end
  end

  assign rmw_pending_o = rmw_pend_q;

`ifdef STENCIL_WR_FWD_EN
  always_comb begin
    rd_data_o = mem[rd_word_i];
    if (commit_en && (commit_word == rd_word_i)) begin
      rd_data_o = commit_data;
    end
  end
`else
  assign rd_data_o = mem[rd_word_i];
`endif

endmodule

// File: rtl/gpu_stencil_store.sv
// gpu_stencil_store
// Banked stencil word store with masked writes and a whole-store fill.
//
// Optional feature: define STENCIL_WR_FWD_EN so that a read accepted in the
// same cycle as a write commit to the same address returns the new word;
// otherwise it returns the word as it was before that commit.
//
// Handshake: a request is accepted on a rising clk_i edge where its req and
// ready are both high; ready depends only on state and clr_req_i, never on
// the request itself. An accepted read raises rd_valid_o for exactly the
// following cycle with the word on rd_value_o, which then holds until the
// next read result.
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   rd_req_i, rd_addr_i, rd_ready_o      read request
//   rd_valid_o, rd_value_o               read result (one cycle later)
//   wr_req_i, wr_addr_i, wr_mask_i,
//   wr_value_i, wr_ready_o               masked write request
//   clr_req_i, clr_value_i, clr_busy_o   level fill request, fill running
//   clr_state_o                          clear FSM state (debug)
module gpu_stencil_store
  import gpu_stencil_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_ready_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_value_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_mask_i,
  input  logic [DATA_W-1:0] wr_value_i,
  output logic              wr_ready_o,
  input  logic              clr_req_i,
  input  logic [DATA_W-1:0] clr_value_i,
  output logic              clr_busy_o,
  output clr_state_e        clr_state_o
);

  localparam int BB     = calc_bb(NUM_BANKS);
  localparam int WORD_W = ADDR_W - BB;
  localparam int DEPTH  = calc_depth(ADDR_W, BB);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

  logic [BB-1:0]     rd_bank;
  logic [BB-1:0]     wr_bank;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] wr_word;

  assign rd_bank = BB'(addr_bank(32'(rd_addr_i), BB));
  assign wr_bank = BB'(addr_bank(32'(wr_addr_i), BB));
  assign rd_word = WORD_W'(addr_word(32'(rd_addr_i), BB));
  assign wr_word = WORD_W'(addr_word(32'(wr_addr_i), BB));

  clr_state_e        state_q;
  logic [WORD_W-1:0] cnt_q;
  logic [DATA_W-1:0] clr_value_q;

  logic [NUM_BANKS-1:0] bank_rmw_pend;
  logic [DATA_W-1:0]    bank_rd_data [NUM_BANKS];

  logic rmw_pending;
  logic in_idle;
  logic in_clear;
  logic rd_fire;
  logic wr_fire;
  logic wr_any;

  assign rmw_pending = |bank_rmw_pend;
  assign in_idle     = (state_q == ST_IDLE);
  assign in_clear    = (state_q == ST_CLEAR);

  assign rd_ready_o = in_idle & ~clr_req_i;
  assign wr_ready_o = in_idle & ~clr_req_i & ~rmw_pending;
  assign rd_fire    = rd_req_i & rd_ready_o;
  assign wr_fire    = wr_req_i & wr_ready_o;
  // An all-zero mask is accepted but never reaches a bank.
  assign wr_any     = |wr_mask_i;

  assign clr_busy_o  = in_clear;
  assign clr_state_o = state_q;

  // Clear FSM. Entry waits for a pending merge to commit so the merged word
  // is then overwritten by the sweep rather than racing it. The fill value
  // is captured at entry so the requester may change clr_value_i freely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_value_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req_i && !rmw_pending) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            clr_value_q <= clr_value_i;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LAST_WORD) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + WORD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Read result register: one-cycle latency, value held between results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= 1'b0;
      rd_value_o <= '0;
    end else begin
      rd_valid_o <= rd_fire;
      if (rd_fire) begin
        rd_value_o <= bank_rd_data[rd_bank];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    gpu_stencil_bank #(
      .DATA_W (DATA_W),
      .WORD_W (WORD_W)
    ) u_bank (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .rd_word_i     (rd_word),
      .rd_data_o     (bank_rd_data[b]),
      .wr_en_i       (wr_fire & wr_any & (wr_bank == BB'(b))),
      .wr_word_i     (wr_word),
      .wr_mask_i     (wr_mask_i),
      .wr_value_i    (wr_value_i),
      .clr_en_i      (in_clear),
      .clr_word_i    (cnt_q),
      .clr_value_i   (clr_value_q),
      .rmw_pending_o (bank_rmw_pend[b])
    );
  end

endmodule

// File: doc/gpu_stencil_store.md
GPU_STENCIL_STORE -- requirements
Module: gpu_stencil_store

Interface
- REQ-001 SHALL have parameter DATA_W, default 16, stencil word width in bits.
- REQ-002 SHALL have parameter NUM_BANKS, default 8, bank count; power of 2, range 2..16.
- REQ-003 SHALL have parameter ADDR_W, default 15, word address width.
- REQ-004 SHALL have port clk_i, in, 1, the single clock.
- REQ-005 SHALL have port rst_ni, in, 1, reset; asynchronous, active-low.
- REQ-006 SHALL have read ports:
  - rd_req_i, in, 1, read request.
  - rd_addr_i, in, ADDR_W, read address.
  - rd_ready_o, out, 1, read accepted this cycle.
- REQ-007 SHALL have read-result ports:
  - rd_valid_o, out, 1, read data valid.
  - rd_value_o, out, DATA_W, read data.
- REQ-008 SHALL have write ports:
  - wr_req_i, in, 1, write request.
  - wr_addr_i, in, ADDR_W, write address.
  - wr_mask_i, in, DATA_W, per-bit write enable.
  - wr_value_i, in, DATA_W, write data.
  - wr_ready_o, out, 1, write accepted this cycle.
- REQ-009 SHALL have clear ports:
  - clr_req_i, in, 1, level request to fill the whole store.
  - clr_value_i, in, DATA_W, fill value.
  - clr_busy_o, out, 1, fill in progress.

Function
- REQ-010 SHALL decode addresses as: bank = addr[BB-1:0], word = addr[ADDR_W-1:BB], where BB = log2(NUM_BANKS) and DEPTH = 2^(ADDR_W-BB).
- REQ-011 SHALL accept a read when rd_req_i & rd_ready_o. rd_valid_o SHALL pulse exactly 1 cycle later, with rd_value_o holding the word. rd_value_o SHALL hold its last value otherwise.
- REQ-012 SHALL commit a full-mask write (all ones) in its accept cycle. wr_ready_o SHALL stay high afterwards.
- REQ-013 SHALL handle a partial-mask write as read-modify-write:
  - accept cycle N: read the old word;
  - cycle N+1: write (value & mask) | (old & ~mask);
  - wr_ready_o SHALL be low in N+1 (RMW pending).
- REQ-014 SHALL accept an all-zero-mask write without modifying RAM and without stalling.
- REQ-015 SHALL allow reads and writes to any banks in the same cycle, with no stall or error.
- REQ-016 SHALL implement a clear FSM with states IDLE and CLEAR:
  - IDLE->CLEAR when clr_req_i & !rmw_pending;
  - in CLEAR, word counter 0..DEPTH-1 writes clr_value_i (sampled at entry) to all banks each cycle;
  - CLEAR->IDLE after word DEPTH-1;
  - the sweep SHALL take exactly DEPTH cycles.
- REQ-017 SHALL drive clr_busy_o high exactly in CLEAR. clr_req_i SHALL be ignored while in CLEAR.
- REQ-018 SHALL drive handshake readies as:
  - rd_ready_o = IDLE & !clr_req_i;
  - wr_ready_o = IDLE & !clr_req_i & !rmw_pending.
- REQ-019 SHALL complete a read accepted on the cycle before CLEAR entry normally.

Reset
- REQ-020 SHALL, on rst_ni low, asynchronously force:
  - FSM to IDLE, counter 0, rmw_pending 0;
  - rd_valid_o 0, rd_value_o 0, clr_busy_o 0.
- REQ-021 SHALL NOT initialise RAM contents. Reset mid-CLEAR or mid-RMW SHALL abort; already-written words persist.

Configuration
- REQ-022 With STENCIL_WR_FWD_EN defined, a read accepted in the same cycle as a write commit (full-mask or RMW N+1) to the same address SHALL return the newly committed word.
- REQ-023 Without STENCIL_WR_FWD_EN, that read SHALL return the pre-write word. No bypass logic SHALL be synthesised.

Structure
- REQ-024 SHALL place the FSM state enum, the BB and DEPTH derivation functions and the address-split helpers in package gpu_stencil_pkg.
- REQ-025 SHALL use a sub-module gpu_stencil_bank per bank: dual-port RAM plus RMW merge stage, generated NUM_BANKS times.

Verification
- REQ-026 Full-mask write: addr 0x0012, value 0xBEEF; read 0x0012 next cycle -> rd_valid_o 1 cycle later, rd_value_o 0xBEEF, wr_ready_o never low.
- REQ-027 Partial write: word holds 0xFFFF; write mask 0x00FF, value 0x1234 -> wr_ready_o low 1 cycle; readback 0xFF34.
- REQ-028 Same-cycle read/write to 0x0040 (old 0x0000, new 0xAAAA) -> returns 0xAAAA with STENCIL_WR_FWD_EN, 0x0000 without.
- REQ-029 Clear with clr_value_i 0x5A5A (defaults: 4096 cycles) -> clr_busy_o high 4096 cycles; both readies low throughout; random readback 0x5A5A.
- REQ-030 clr_req_i asserted during RMW cycle N+1 -> CLEAR entry deferred 1 cycle; merged word then overwritten by fill.
- REQ-031 rst_ni dropped at sweep word 100 -> clr_busy_o 0 immediately; words 0..99 read 0x5A5A, word 200 keeps its old value.
